// File: rtl/mycpu_pkg.sv
// Shared widths and bus field positions for the memory stage and its neighbours.
package mycpu_pkg;

  localparam int ES2MS_WD = 165;
  localparam int MS2WS_WD = 160;
  // {ms_ex, mfc0, res_from_mem, gr_we[3:0], dest[4:0], final_result[31:0]} = 1+1+1+4+5+32
  localparam int MSFWD_WD = 44;

  // execute -> memory bus fields
  localparam int ES_HAS_INT   = 164;
  localparam int ES_OVERFLOW  = 163;
  localparam int ES_BADADDR_H = 162, ES_BADADDR_L = 131;
  localparam int ES_BAD_INST  = 130;
  localparam int ES_BREAK     = 129;
  localparam int ES_ADEL_INST = 128;
  localparam int ES_ADEL_MEM  = 127;
  localparam int ES_ADES_MEM  = 126;
  localparam int ES_BD        = 125;
  localparam int ES_RT_H      = 124, ES_RT_L = 93;
  localparam int ES_DSTCP0_H  = 92,  ES_DSTCP0_L = 88;
  localparam int ES_RES_MEM   = 87;
  localparam int ES_GRWE_H    = 86,  ES_GRWE_L = 83;
  localparam int ES_LH        = 82;
  localparam int ES_LB        = 81;
  localparam int ES_LWL       = 80;
  localparam int ES_LWR       = 79;
  localparam int ES_ERET      = 78;
  localparam int ES_MFC0      = 77;
  localparam int ES_MTC0      = 76;
  localparam int ES_SYSC      = 75;
  localparam int ES_OFF_H     = 74,  ES_OFF_L = 73;
  localparam int ES_EXT       = 72;
  localparam int ES_DEST_H    = 71,  ES_DEST_L = 67;
  localparam int ES_SEL_H     = 66,  ES_SEL_L = 64;
  localparam int ES_RES_H     = 63,  ES_RES_L = 32;
  localparam int ES_PC_H      = 31,  ES_PC_L = 0;

  // memory -> writeback bus fields (bit 159 reserved, driven 0)
  localparam int MW_EX        = 158;
  localparam int MW_HAS_INT   = 157;
  localparam int MW_OVERFLOW  = 156;
  localparam int MW_BADADDR_H = 155, MW_BADADDR_L = 124;
  localparam int MW_BAD_INST  = 123;
  localparam int MW_BREAK     = 122;
  localparam int MW_ADEL_INST = 121;
  localparam int MW_ADEL_MEM  = 120;
  localparam int MW_ADES_MEM  = 119;
  localparam int MW_BD        = 118;
  localparam int MW_RT_H      = 117, MW_RT_L = 86;
  localparam int MW_DSTCP0_H  = 85,  MW_DSTCP0_L = 81;
  localparam int MW_SEL_H     = 80,  MW_SEL_L = 78;
  localparam int MW_ERET      = 77;
  localparam int MW_MFC0      = 76;
  localparam int MW_MTC0      = 75;
  localparam int MW_SYSC      = 74;
  localparam int MW_RES_MEM   = 73;
  localparam int MW_GRWE_H    = 72,  MW_GRWE_L = 69;
  localparam int MW_DEST_H    = 68,  MW_DEST_L = 64;
  localparam int MW_RES_H     = 63,  MW_RES_L = 32;
  localparam int MW_PC_H      = 31,  MW_PC_L = 0;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks byte/half/partial word from the read word and extends it.
module load_align (
  input  logic [31:0] i_rd,
  input  logic [1:0]  i_off,
  input  logic        i_lb,
  input  logic        i_lh,
  input  logic        i_lwl,
  input  logic        i_lwr,
  input  logic        i_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [1:0]  w_lwl_sh;

  // select the addressed lane, then extend or shift per load type; plain lw falls through
  always_comb begin
    w_byte   = i_rd[{i_off, 3'b000} +: 8];
    w_half   = i_rd[{i_off[1], 4'b0000} +: 16];
    w_lwl_sh = 2'd3 - i_off;
    if (i_lb)       o_data = {{24{i_ext & w_byte[7]}}, w_byte};
    else if (i_lh)  o_data = {{16{i_ext & w_half[15]}}, w_half};
    else if (i_lwl) o_data = i_rd << {w_lwl_sh, 3'b000};
    else if (i_lwr) o_data = i_rd >> {i_off, 3'b000};
    else            o_data = i_rd;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute payload, aligns load data from the
// synchronous SRAM, forms the exception summary and drives writeback/forwarding buses.
import mycpu_pkg::*;

module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = ES2MS_WD,
  parameter int MS_TO_WS_BUS_WD = MS2WS_WD,
  parameter int MS_FWD_BUS_WD   = MSFWD_WD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_es_bus,
  output logic [MS_FWD_BUS_WD-1:0]   ms_to_ds_bus
);

  logic                       r_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic                       r_first;   // first cycle after capture: SRAM word is live
  logic [31:0]                r_rdata;

  logic                       w_ready_go;
  logic                       w_ex;
  logic [3:0]                 w_gr_we;
  logic [31:0]                w_rd;
  logic [31:0]                w_load;
  logic [31:0]                w_final;
  logic [MS_TO_WS_BUS_WD-1:0] w_ws_bus;

  assign w_ready_go     = 1'b1;
  assign ms_allowin     = !r_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_valid && w_ready_go && !flush;

  // stage occupancy: reset and flush empty it, otherwise refill when allowed
  always_ff @(posedge clk) begin
    if (reset)           r_valid <= 1'b0;
    else if (flush)      r_valid <= 1'b0;
    else if (ms_allowin) r_valid <= es_to_ms_valid;
  end

  // payload register, held while writeback stalls
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) r_bus <= es_to_ms_bus;
  end

  // mark the cycle in which the SRAM read word belongs to the held instruction
  always_ff @(posedge clk) begin
    if (reset) r_first <= 1'b0;
    else       r_first <= es_to_ms_valid && ms_allowin && !flush;
  end

  // keep the read word so a stall cannot lose it when the SRAM output moves on
  always_ff @(posedge clk) begin
    if (r_first) r_rdata <= data_sram_rdata;
  end

  assign w_rd = r_first ? data_sram_rdata : r_rdata;

  load_align u_align (
    .i_rd   (w_rd),
    .i_off  (r_bus[ES_OFF_H:ES_OFF_L]),
    .i_lb   (r_bus[ES_LB]),
    .i_lh   (r_bus[ES_LH]),
    .i_lwl  (r_bus[ES_LWL]),
    .i_lwr  (r_bus[ES_LWR]),
    .i_ext  (r_bus[ES_EXT]),
    .o_data (w_load)
  );

  assign w_ex = r_valid & (r_bus[ES_HAS_INT] | r_bus[ES_OVERFLOW] | r_bus[ES_BAD_INST] |
                           r_bus[ES_BREAK] | r_bus[ES_ADEL_INST] | r_bus[ES_ADEL_MEM] |
                           r_bus[ES_ADES_MEM] | r_bus[ES_SYSC]);
  assign w_gr_we = w_ex ? 4'h0 : r_bus[ES_GRWE_H:ES_GRWE_L];
  assign w_final = r_bus[ES_RES_MEM] ? w_load : r_bus[ES_RES_H:ES_RES_L];

  // pack the writeback payload; CP0 side-band fields pass through untouched
  always_comb begin
    w_ws_bus                              = '0;
    w_ws_bus[MW_EX]                       = w_ex;
    w_ws_bus[MW_HAS_INT]                  = r_bus[ES_HAS_INT];
    w_ws_bus[MW_OVERFLOW]                 = r_bus[ES_OVERFLOW];
    w_ws_bus[MW_BADADDR_H:MW_BADADDR_L]   = r_bus[ES_BADADDR_H:ES_BADADDR_L];
    w_ws_bus[MW_BAD_INST]                 = r_bus[ES_BAD_INST];
    w_ws_bus[MW_BREAK]                    = r_bus[ES_BREAK];
    w_ws_bus[MW_ADEL_INST]                = r_bus[ES_ADEL_INST];
    w_ws_bus[MW_ADEL_MEM]                 = r_bus[ES_ADEL_MEM];
    w_ws_bus[MW_ADES_MEM]                 = r_bus[ES_ADES_MEM];
    w_ws_bus[MW_BD]                       = r_bus[ES_BD];
    w_ws_bus[MW_RT_H:MW_RT_L]             = r_bus[ES_RT_H:ES_RT_L];
    w_ws_bus[MW_DSTCP0_H:MW_DSTCP0_L]     = r_bus[ES_DSTCP0_H:ES_DSTCP0_L];
    w_ws_bus[MW_SEL_H:MW_SEL_L]           = r_bus[ES_SEL_H:ES_SEL_L];
    w_ws_bus[MW_ERET]                     = r_bus[ES_ERET];
    w_ws_bus[MW_MFC0]                     = r_bus[ES_MFC0];
    w_ws_bus[MW_MTC0]                     = r_bus[ES_MTC0];
    w_ws_bus[MW_SYSC]                     = r_bus[ES_SYSC];
    w_ws_bus[MW_RES_MEM]                  = r_bus[ES_RES_MEM];
    w_ws_bus[MW_GRWE_H:MW_GRWE_L]         = w_gr_we;
    w_ws_bus[MW_DEST_H:MW_DEST_L]         = r_bus[ES_DEST_H:ES_DEST_L];
    w_ws_bus[MW_RES_H:MW_RES_L]           = w_final;
    w_ws_bus[MW_PC_H:MW_PC_L]             = r_bus[ES_PC_H:ES_PC_L];
  end

  assign ms_to_ws_bus = r_valid ? w_ws_bus : '0;
  assign ms_to_es_bus = r_valid & (w_ex | r_bus[ES_ERET]);
  assign ms_to_ds_bus = (r_valid && !flush) ?
                        {w_ex, r_bus[ES_MFC0], r_bus[ES_RES_MEM], w_gr_we,
                         r_bus[ES_DEST_H:ES_DEST_L], w_final} : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of the memory stage against a field-level reference model.
module tb_mem_stage;
  import mycpu_pkg::*;

  logic                clk = 1'b0;
  logic                reset, flush, ws_allowin, ms_allowin, es_to_ms_valid;
  logic                ms_to_ws_valid, ms_to_es_bus;
  logic [ES2MS_WD-1:0] es_to_ms_bus;
  logic [MS2WS_WD-1:0] ms_to_ws_bus;
  logic [31:0]         data_sram_rdata;
  logic [MSFWD_WD-1:0] ms_to_ds_bus;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .ws_allowin(ws_allowin),
    .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_rdata(data_sram_rdata), .ms_to_es_bus(ms_to_es_bus), .ms_to_ds_bus(ms_to_ds_bus)
  );

  localparam int OP_LW = 0, OP_LB = 1, OP_LH = 2, OP_LWL = 3, OP_LWR = 4;

  typedef struct {
    logic        has_int, ovf, bad_inst, brk, adel_inst, adel_mem, ades_mem, bd;
    logic [31:0] bad_addr, rt;
    logic [4:0]  dstcp0, dest;
    logic        res_mem, eret, mfc0, mtc0, sysc, ext;
    logic [3:0]  we;
    int          op;
    logic [1:0]  off;
    logic [2:0]  sel;
    logic [31:0] result, pc;
  } ins_t;

  function automatic ins_t base();
    ins_t f;
    f = '{default: '0};
    f.res_mem = 1'b1; f.we = 4'hF; f.dest = 5'd3;
    f.result = 32'hDEAD_BEEF; f.pc = 32'hBFC0_0100; f.bad_addr = 32'h1234_5678;
    return f;
  endfunction

  function automatic ins_t rand_ins();
    ins_t f;
    f.has_int = ($urandom_range(0, 15) == 0); f.ovf = ($urandom_range(0, 15) == 0);
    f.bad_inst = ($urandom_range(0, 15) == 0); f.brk = ($urandom_range(0, 15) == 0);
    f.adel_inst = ($urandom_range(0, 15) == 0); f.adel_mem = ($urandom_range(0, 15) == 0);
    f.ades_mem = ($urandom_range(0, 15) == 0); f.sysc = ($urandom_range(0, 15) == 0);
    f.eret = ($urandom_range(0, 7) == 0); f.bd = 1'($urandom);
    f.bad_addr = $urandom; f.rt = $urandom; f.dstcp0 = 5'($urandom); f.dest = 5'($urandom);
    f.res_mem = ($urandom_range(0, 3) != 0); f.mfc0 = 1'($urandom); f.mtc0 = 1'($urandom);
    f.ext = 1'($urandom); f.we = 4'($urandom); f.op = $urandom_range(0, 4);
    f.off = 2'($urandom); f.sel = 3'($urandom); f.result = $urandom; f.pc = $urandom;
    return f;
  endfunction

  function automatic logic [ES2MS_WD-1:0] pack(input ins_t f);
    logic [ES2MS_WD-1:0] b;
    b = '0;
    b[164] = f.has_int; b[163] = f.ovf; b[162:131] = f.bad_addr; b[130] = f.bad_inst;
    b[129] = f.brk; b[128] = f.adel_inst; b[127] = f.adel_mem; b[126] = f.ades_mem;
    b[125] = f.bd; b[124:93] = f.rt; b[92:88] = f.dstcp0; b[87] = f.res_mem; b[86:83] = f.we;
    b[82] = (f.op == OP_LH); b[81] = (f.op == OP_LB); b[80] = (f.op == OP_LWL);
    b[79] = (f.op == OP_LWR); b[78] = f.eret; b[77] = f.mfc0; b[76] = f.mtc0; b[75] = f.sysc;
    b[74:73] = f.off; b[72] = f.ext; b[71:67] = f.dest; b[66:64] = f.sel;
    b[63:32] = f.result; b[31:0] = f.pc;
    return b;
  endfunction

  function automatic logic [31:0] ref_load(input int op, input logic [1:0] off,
                                           input logic ext, input logic [31:0] rd);
    logic [31:0] v;
    case (op)
      OP_LB:  begin v = (rd >> (8 * off)) & 32'hFF;  if (ext && v[7])  v = v | 32'hFFFF_FF00; end
      OP_LH:  begin v = (rd >> (16 * off[1])) & 32'hFFFF; if (ext && v[15]) v = v | 32'hFFFF_0000; end
      OP_LWL: v = rd << (8 * (3 - off));
      OP_LWR: v = rd >> (8 * off);
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // checks every output for the instruction currently held in the stage
  task automatic check_ins(input string tag, input ins_t f, input logic [31:0] rd);
    logic        ex;
    logic [3:0]  we;
    logic [31:0] fr;
    ex = f.has_int | f.ovf | f.bad_inst | f.brk | f.adel_inst | f.adel_mem | f.ades_mem | f.sysc;
    we = ex ? 4'h0 : f.we;
    fr = f.res_mem ? ref_load(f.op, f.off, f.ext, rd) : f.result;
    chk({tag, ".valid"}, 64'(ms_to_ws_valid), 64'd1);
    chk({tag, ".res"}, 64'(ms_to_ws_bus[MW_RES_H:MW_RES_L]), 64'(fr));
    chk({tag, ".we"}, 64'(ms_to_ws_bus[MW_GRWE_H:MW_GRWE_L]), 64'(we));
    chk({tag, ".badaddr"}, 64'(ms_to_ws_bus[MW_BADADDR_H:MW_BADADDR_L]), 64'(f.bad_addr));
    chk({tag, ".pc"}, 64'(ms_to_ws_bus[MW_PC_H:MW_PC_L]), 64'(f.pc));
    chk({tag, ".es"}, 64'(ms_to_es_bus), 64'(ex | f.eret));
    chk({tag, ".ds"}, 64'(ms_to_ds_bus), 64'({ex, f.mfc0, f.res_mem, we, f.dest, fr}));
  endtask

  // issue one instruction, present its read word, and check it in its first valid cycle
  task automatic run_one(input string tag, input ins_t f, input logic [31:0] rd);
    es_to_ms_valid = 1'b1; es_to_ms_bus = pack(f);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0; data_sram_rdata = rd;
    #1;
    check_ins(tag, f, rd);
  endtask

  initial begin
    ins_t        f, g, cur;
    logic [31:0] rd;
    logic        nv;

    reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ws_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rst.allowin", 64'(ms_allowin), 64'd1);
    chk("rst.es", 64'(ms_to_es_bus), 64'd0);
    chk("rst.ds", 64'(ms_to_ds_bus), 64'd0);
    chk("rst.ws_bus_res", 64'(ms_to_ws_bus[MW_RES_H:MW_RES_L]), 64'd0);
    reset = 1'b0;

    // byte loads with and without sign extension
    f = base(); f.op = OP_LB; f.off = 2'd2; f.ext = 1'b1;
    run_one("lb_sx", f, 32'h1280_5678);
    chk("lb_sx.lit", 64'(ms_to_ws_bus[MW_RES_H:MW_RES_L]), 64'hFFFF_FF80);
    f.ext = 1'b0;
    run_one("lb_zx", f, 32'h1280_5678);
    chk("lb_zx.lit", 64'(ms_to_ws_bus[MW_RES_H:MW_RES_L]), 64'h0000_0080);

    // partial word loads keep their precomputed strobes
    f = base(); f.op = OP_LWL; f.off = 2'd1; f.we = 4'b1100;
    run_one("lwl", f, 32'hAABB_CCDD);
    chk("lwl.lit", 64'(ms_to_ws_bus[MW_RES_H:MW_RES_L]), 64'hCCDD_0000);
    f.op = OP_LWR; f.we = 4'b0111;
    run_one("lwr", f, 32'hAABB_CCDD);
    chk("lwr.lit", 64'(ms_to_ws_bus[MW_RES_H:MW_RES_L]), 64'h00AA_BBCC);

    // stall: result must stay the word read in the first cycle
    f = base(); f.op = OP_LW; rd = 32'h1122_3344;
    es_to_ms_valid = 1'b1; es_to_ms_bus = pack(f);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_rdata = rd;
    #1;
    check_ins("stall0", f, rd);
    chk("stall0.allowin", 64'(ms_allowin), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      data_sram_rdata = ~rd ^ 32'(i);
      #1;
      chk("stall.res", 64'(ms_to_ws_bus[MW_RES_H:MW_RES_L]), 64'(rd));
      chk("stall.allowin", 64'(ms_allowin), 64'd0);
      chk("stall.valid", 64'(ms_to_ws_valid), 64'd1);
    end
    ws_allowin = 1'b1;
    #1 chk("stall.release", 64'(ms_allowin), 64'd1);
    @(posedge clk); #2;
    chk("stall.drain", 64'(ms_to_ws_valid), 64'd0);

    // address error on a load: writes suppressed, bad address kept
    f = base(); f.adel_mem = 1'b1; f.dest = 5'd5; f.bad_addr = 32'h8000_0003;
    run_one("adel", f, 32'h5555_AAAA);
    chk("adel.es_lit", 64'(ms_to_es_bus), 64'd1);

    // flush with an instruction held and another arriving
    f = base(); g = base(); g.dest = 5'd9;
    run_one("preflush", f, 32'h0BAD_F00D);
    flush = 1'b1; es_to_ms_valid = 1'b1; es_to_ms_bus = pack(g);
    #1;
    chk("flush.ws_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("flush.ds", 64'(ms_to_ds_bus), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; es_to_ms_valid = 1'b0;
    #1;
    chk("postflush.ws_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("postflush.allowin", 64'(ms_allowin), 64'd1);
    chk("postflush.es", 64'(ms_to_es_bus), 64'd0);

    // reset while stalled
    f = base(); f.eret = 1'b1;
    run_one("prerst", f, 32'h7777_0000);
    ws_allowin = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rststall.ws_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rststall.allowin", 64'(ms_allowin), 64'd1);
    chk("rststall.es", 64'(ms_to_es_bus), 64'd0);
    chk("rststall.ds", 64'(ms_to_ds_bus), 64'd0);
    chk("rststall.ws_bus", 64'(ms_to_ws_bus[63:0]), 64'd0);
    ws_allowin = 1'b1;

    // randomized back-to-back traffic with bubbles
    cur = base();
    for (int i = 0; i < 60; i++) begin
      g = rand_ins(); nv = ($urandom_range(0, 3) != 0);
      es_to_ms_valid = nv; es_to_ms_bus = pack(g);
      @(posedge clk); #1;
      rd = $urandom;
      data_sram_rdata = rd;
      if (nv) cur = g;
      #1;
      if (nv) check_ins("rand", cur, rd);
      else begin
        chk("rand.idle_valid", 64'(ms_to_ws_valid), 64'd0);
        chk("rand.idle_ds", 64'(ms_to_ds_bus), 64'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
